// File: rtl/nmca_pkg.sv
// Shared types and defaults for the linear-layer scheduler slice.
package nmca_pkg;

    // Default parameter values for the scheduler and its bus interface.
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ACC_WIDTH = 32;
    localparam int DEF_M         = 8;
    localparam int DEF_TIMEOUT   = 1024;

    // Scheduler FSM states, exported on the debug port as well.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        START = 3'd2,
        RUN   = 3'd3,
        RESP  = 3'd4
    } sched_state_t;

    // Round-robin candidate: the requester 'off' positions above 'base', wrapped.
    function automatic int rr_index(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/linear_layer_scheduler_if.sv
// Bus between the scheduler, its requesters and the shared MAC engine.
//
// Response handshake: result_valid is raised by the scheduler and, once high,
// stays high with result/result_id/result_err frozen until a cycle in which
// result_ready is also high; that cycle is the transfer. result_ready may be
// driven freely and has no effect while result_valid is low.
interface linear_layer_scheduler_if
    import nmca_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int M         = DEF_M
);
    localparam int IDXW = $clog2(NUM_REQ);

    // Requester side
    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ-1:0]          gnt;

    // Engine side
    logic [IDXW-1:0]             eng_sel;
    logic                        eng_clr;
    logic                        eng_start;
    logic signed [ACC_WIDTH-1:0] eng_out;
    logic                        eng_out_valid;
    logic                        eng_done;

    // Response side
    logic signed [ACC_WIDTH-1:0] result [M];
    logic                        result_valid;
    logic [IDXW-1:0]             result_id;
    logic                        result_err;
    logic                        result_ready;

    // Scheduler view
    modport master (
        input  req, eng_out, eng_out_valid, eng_done, result_ready,
        output gnt, eng_sel, eng_clr, eng_start,
               result, result_valid, result_id, result_err
    );

    // Requesters + engine view
    modport slave (
        output req, eng_out, eng_out_valid, eng_done, result_ready,
        input  gnt, eng_sel, eng_clr, eng_start,
               result, result_valid, result_id, result_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational one-hot round-robin pick, searching upward from last+1.
module rr_arbiter
    import nmca_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDXW   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDXW-1:0]    last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDXW-1:0]    idx_o,
    output logic               any_o
);

    logic [IDXW-1:0] cand;

    // Walk the requesters starting just after the last winner; first set bit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDXW'(rr_index(int'(last_i), off, NUM_REQ));
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/linear_layer_scheduler.sv
// Shares one linear_layer MAC engine between NUM_REQ requesters: arbitrates,
// clears/starts the engine, collects M beats and returns them with a watchdog.
module linear_layer_scheduler
    import nmca_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int M         = DEF_M,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    linear_layer_scheduler_if.master  bus,
    output sched_state_t              state_o
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int BW   = $clog2(M + 1);
    localparam int WW   = $clog2(TIMEOUT + 1);

    sched_state_t                state_q, state_d;
    logic [NUM_REQ-1:0]          gnt_q, gnt_d;
    logic [IDXW-1:0]             sel_q, sel_d;
    logic [IDXW-1:0]             last_q, last_d;
    logic [BW-1:0]               beat_q, beat_d;
    logic [WW-1:0]               wdog_q, wdog_d;
    logic                        err_q, err_d;
    logic                        wr_en;

    logic                        clr_q;
    logic                        start_q;
    logic                        valid_q;
    logic [IDXW-1:0]             rid_q;
    logic                        rerr_q;
    logic signed [ACC_WIDTH-1:0] result_q [M];

    logic [NUM_REQ-1:0]          arb_gnt;
    logic [IDXW-1:0]             arb_idx;
    logic                        arb_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i  (bus.req),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    // Next-state, grant bookkeeping, beat collection and watchdog.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        beat_d  = beat_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_d   = arb_gnt;
                    sel_d   = arb_idx;
                    last_d  = arb_idx;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                beat_d  = '0;
                wdog_d  = '0;
                err_d   = 1'b0;
                state_d = START;
            end
            START: begin
                state_d = RUN;
            end
            RUN: begin
                // Beats beyond M are dropped and flag the job as bad.
                if (bus.eng_out_valid) begin
                    if (beat_q < BW'(M)) begin
                        wr_en  = 1'b1;
                        beat_d = beat_q + BW'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (wdog_q != WW'(TIMEOUT)) begin
                    wdog_d = wdog_q + WW'(1);
                end
                // Done is judged on the count including a same-cycle beat.
                if (bus.eng_done) begin
                    if (beat_d != BW'(M)) begin
                        err_d = 1'b1;
                    end
                    state_d = RESP;
                end else if (wdog_d == WW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.result_ready) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and job-context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= IDXW'(NUM_REQ - 1);
            beat_q  <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    // Registered engine controls and response; the engine is held cleared in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_q   <= 1'b1;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            rid_q   <= '0;
            rerr_q  <= 1'b0;
        end else begin
            clr_q   <= (state_d == CLEAR);
            start_q <= (state_d == START);
            valid_q <= (state_d == RESP);
            if (state_q == RUN && state_d == RESP) begin
                rid_q  <= sel_q;
                rerr_q <= err_d;
            end
        end
    end

    // Result buffer: beat k lands in entry k; untouched entries keep old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < M; k++) begin
                result_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < M; k++) begin
                if (wr_en && beat_q == BW'(k)) begin
                    result_q[k] <= bus.eng_out;
                end
            end
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.eng_sel      = sel_q;
    assign bus.eng_clr      = clr_q;
    assign bus.eng_start    = start_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.result_id    = rid_q;
    assign bus.result_err   = rerr_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_linear_layer_scheduler.sv
// Directed bench for linear_layer_scheduler (NUM_REQ=4, M=3, TIMEOUT=16).
module tb_linear_layer_scheduler;
    import nmca_pkg::*;

    logic         clk;
    logic         rst_n;
    sched_state_t state_o;
    int           n_cmp;
    int           n_err;

    linear_layer_scheduler_if #(.NUM_REQ(4), .ACC_WIDTH(32), .M(3)) bus ();

    linear_layer_scheduler #(
        .NUM_REQ   (4),
        .ACC_WIDTH (32),
        .M         (3),
        .TIMEOUT   (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.master),
        .state_o (state_o)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for a state; an expired budget is reported as a failed check.
    task automatic wait_state(input sched_state_t s, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (state_o == s) break;
            tick();
        end
        check(tag, 32'(state_o), 32'(s));
    endtask

    task automatic beat(input logic [31:0] v);
        bus.eng_out       = v;
        bus.eng_out_valid = 1'b1;
        tick();
        bus.eng_out_valid = 1'b0;
    endtask

    task automatic done_pulse();
        bus.eng_done = 1'b1;
        tick();
        bus.eng_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int exp_gnt [5];
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.req           = '0;
        bus.eng_out       = '0;
        bus.eng_out_valid = 1'b0;
        bus.eng_done      = 1'b0;
        bus.result_ready  = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_gnt",    32'(bus.gnt), 0);
        check("rst_sel",    32'(bus.eng_sel), 0);
        check("rst_clr",    32'(bus.eng_clr), 1);
        check("rst_start",  32'(bus.eng_start), 0);
        check("rst_valid",  32'(bus.result_valid), 0);
        check("rst_id",     32'(bus.result_id), 0);
        check("rst_err",    32'(bus.result_err), 0);
        check("rst_res0",   32'(bus.result[0]), 0);
        check("rst_state",  32'(state_o), 32'(IDLE));
        rst_n = 1'b1;
        tick();
        check("clr_fall", 32'(bus.eng_clr), 0);

        // Single job from requester 0
        bus.req = 4'b0001;
        tick();
        check("t1_gnt",    32'(bus.gnt), 1);
        check("t1_clr",    32'(bus.eng_clr), 1);
        check("t1_start0", 32'(bus.eng_start), 0);
        check("t1_sel",    32'(bus.eng_sel), 0);
        tick();
        check("t1_clr_end", 32'(bus.eng_clr), 0);
        check("t1_start",   32'(bus.eng_start), 1);
        tick();
        check("t1_run",       32'(state_o), 32'(RUN));
        check("t1_start_end", 32'(bus.eng_start), 0);
        check("t1_clr_once",  32'(bus.eng_clr), 0);
        beat(32'd5);
        beat(-32'sd7);
        beat(32'd100);
        check("t1_novalid", 32'(bus.result_valid), 0);
        done_pulse();
        check("t1_valid", 32'(bus.result_valid), 1);
        check("t1_r0",    32'(bus.result[0]), 5);
        check("t1_r1",    32'(bus.result[1]), -7);
        check("t1_r2",    32'(bus.result[2]), 100);
        check("t1_id",    32'(bus.result_id), 0);
        check("t1_err",   32'(bus.result_err), 0);
        bus.result_ready = 1'b1;
        bus.req = '0;
        tick();
        check("t1_hs_valid", 32'(bus.result_valid), 0);
        check("t1_hs_gnt",   32'(bus.gnt), 0);
        check("t1_hs_idle",  32'(state_o), 32'(IDLE));
        bus.result_ready = 1'b0;

        // Fairness: all requesting, fresh pointer, ready tied high
        do_reset();
        exp_gnt = '{1, 2, 4, 8, 1};
        bus.req = 4'b1111;
        bus.result_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            wait_state(CLEAR, 4, $sformatf("fair%0d_clear", j));
            check($sformatf("fair%0d_gnt", j), 32'(bus.gnt), exp_gnt[j]);
            wait_state(RUN, 4, $sformatf("fair%0d_run", j));
            beat(32'(j * 10 + 1));
            beat(32'(j * 10 + 2));
            beat(32'(j * 10 + 3));
            done_pulse();
            check($sformatf("fair%0d_valid", j), 32'(bus.result_valid), 1);
            check($sformatf("fair%0d_id", j), 32'(bus.result_id), j % 4);
            check($sformatf("fair%0d_r2", j), 32'(bus.result[2]), j * 10 + 3);
        end
        bus.req = '0;
        tick();
        bus.result_ready = 1'b0;
        check("fair_idle", 32'(state_o), 32'(IDLE));

        // Backpressure: requester 2 wins, response held for 10 cycles
        bus.req = 4'b0100;
        wait_state(CLEAR, 4, "bp_clear");
        check("bp_gnt", 32'(bus.gnt), 4);
        wait_state(RUN, 4, "bp_run");
        beat(32'd11);
        beat(32'd22);
        beat(32'd33);
        done_pulse();
        bus.req = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 32'(bus.result_valid), 1);
            check("bp_r1",    32'(bus.result[1]), 22);
            check("bp_gnt_hold", 32'(bus.gnt), 4);
            tick();
        end
        check("bp_id", 32'(bus.result_id), 2);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check("bp_hs_valid", 32'(bus.result_valid), 0);
        check("bp_hs_gnt",   32'(bus.gnt), 0);
        tick();
        check("bp_next_gnt", 32'(bus.gnt), 8);
        bus.req = '0;

        // Short job: 2 beats then done on requester 3
        wait_state(RUN, 4, "short_run");
        beat(32'd7);
        beat(32'd8);
        done_pulse();
        check("short_valid", 32'(bus.result_valid), 1);
        check("short_err",   32'(bus.result_err), 1);
        check("short_id",    32'(bus.result_id), 3);
        check("short_r0",    32'(bus.result[0]), 7);
        check("short_r1",    32'(bus.result[1]), 8);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;

        // Long job: 4 beats with M=3 on requester 1
        bus.req = 4'b0010;
        wait_state(CLEAR, 4, "long_clear");
        check("long_gnt", 32'(bus.gnt), 2);
        wait_state(RUN, 4, "long_run");
        beat(32'd1);
        beat(32'd2);
        beat(32'd3);
        beat(32'd4);
        done_pulse();
        check("long_valid", 32'(bus.result_valid), 1);
        check("long_err",   32'(bus.result_err), 1);
        check("long_id",    32'(bus.result_id), 1);
        check("long_r0",    32'(bus.result[0]), 1);
        check("long_r1",    32'(bus.result[1]), 2);
        check("long_r2",    32'(bus.result[2]), 3);
        bus.req = '0;
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;

        // Watchdog: engine never finishes; requester drops req mid-job
        bus.req = 4'b0001;
        wait_state(RUN, 6, "wd_run");
        check("wd_gnt", 32'(bus.gnt), 1);
        bus.req = '0;
        for (int c = 0; c < 15; c++) tick();
        check("wd_still_run", 32'(state_o), 32'(RUN));
        check("wd_novalid",   32'(bus.result_valid), 0);
        tick();
        check("wd_valid", 32'(bus.result_valid), 1);
        check("wd_err",   32'(bus.result_err), 1);
        check("wd_id",    32'(bus.result_id), 0);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;

        // Mid-job reset, then a pending request is served normally
        bus.req = 4'b0001;
        wait_state(RUN, 6, "mr_run");
        beat(32'd9);
        rst_n = 1'b0;
        #1;
        check("mr_gnt",   32'(bus.gnt), 0);
        check("mr_clr",   32'(bus.eng_clr), 1);
        check("mr_start", 32'(bus.eng_start), 0);
        check("mr_valid", 32'(bus.result_valid), 0);
        check("mr_res0",  32'(bus.result[0]), 0);
        check("mr_state", 32'(state_o), 32'(IDLE));
        bus.req = 4'b0010;
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_gnt2", 32'(bus.gnt), 2);
        check("mr_sel2", 32'(bus.eng_sel), 1);
        check("mr_clr2", 32'(bus.eng_clr), 1);
        wait_state(RUN, 4, "mr_run2");
        beat(32'd40);
        beat(32'd50);
        beat(32'd60);
        done_pulse();
        check("mr_valid2", 32'(bus.result_valid), 1);
        check("mr_id2",    32'(bus.result_id), 1);
        check("mr_err2",   32'(bus.result_err), 0);
        check("mr_r2",     32'(bus.result[2]), 60);
        bus.req = '0;
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
        check("mr_done_valid", 32'(bus.result_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
